// File: rtl/data_store_buffer_pkg.sv
// Shared types and sizing for the posted-write store buffer.
//   DEPTH       number of store entries (power of two, >= 2)
//   ADDR_WIDTH  address width, matches data_memory
//   DATA_WIDTH  data width, matches data_memory
//   PTR_WIDTH   head/tail pointer width, wraps modulo DEPTH
//   CNT_WIDTH   occupancy counter width, one extra bit to tell full from empty
package data_store_buffer_pkg;

  localparam int DEPTH      = 4;
  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 16;
  localparam int PTR_WIDTH  = $clog2(DEPTH);
  localparam int CNT_WIDTH  = PTR_WIDTH + 1;

  typedef logic [PTR_WIDTH-1:0] ptr_t;
  typedef logic [CNT_WIDTH-1:0] cnt_t;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/data_store_buffer_forward_match.sv
// sb_forward_match: youngest-first address match across the pending stores.
//   addr_i     load address to look up
//   entries_i  store buffer entries {valid, addr, data}
//   head_i     index of the oldest pending entry
//   tail_i     index of the next free slot (youngest entry is tail_i - 1)
//   hit_o      a valid entry matches addr_i
//   data_o     data of the youngest matching entry, zero on a miss
module sb_forward_match
  import data_store_buffer_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  sb_entry_t             entries_i [DEPTH],
  input  ptr_t                  head_i,
  input  ptr_t                  tail_i,
  output logic                  hit_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  ptr_t idx;
  logic done;

  // Walk from the youngest slot backwards; the first valid match wins and the
  // walk stops once the oldest (head) slot has been examined.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment so no latch is inferred.
    hit_o  = 1'b0;
    data_o = '0;
    done   = 1'b0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = tail_i - ptr_t'(k + 1);
      if (!done && entries_i[idx].valid && (entries_i[idx].addr == addr_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
        done   = 1'b1;
      end
      if (idx == head_i) begin
        done = 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_store_buffer.sv
// data_store_buffer: posted-write buffer between the memory stage and data_memory.
// Stores queue in a circular FIFO and drain in program order whenever no load
// is requested; loads own the memory port immediately and are forwarded from
// the youngest matching pending store.
//   clock, reset                        rising-edge clock, async active-high reset
//   cpu_address/cpu_write_data          datapath address and store data
//   cpu_memWrite/cpu_memRead            store / load request
//   cpu_read_data                       combinational load result
//   stall                               store not accepted this cycle
//   empty                               no pending stores
//   mem_address/mem_write_data          to data_memory
//   mem_memWrite/mem_memRead            to data_memory
//   mem_read_data                       from data_memory
module data_store_buffer
  import data_store_buffer_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_write_data,
  input  logic                  cpu_memWrite,
  input  logic                  cpu_memRead,
  output logic [DATA_WIDTH-1:0] cpu_read_data,
  output logic                  stall,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_memWrite,
  output logic                  mem_memRead,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  ptr_t                  head_q, head_d;
  ptr_t                  tail_q, tail_d;
  cnt_t                  count_q, count_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  load_req;
  sb_entry_t             entries [DEPTH];
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;

  assign full  = (count_q == cnt_t'(DEPTH));
  assign empty = (count_q == '0);

  // A simultaneous store+load is a store; the load half is dropped.
  assign load_req = cpu_memRead & ~cpu_memWrite;
  assign push     = cpu_memWrite & ~full;
  // Any asserted read request keeps the port from draining, including the
  // illegal store+load combination.
  assign pop      = ~cpu_memRead & ~empty;

  // Stall is purely a function of the current occupancy: a drain in the same
  // cycle frees a slot only for the following cycle.
  assign stall = ~reset & cpu_memWrite & full;

  always_comb begin
    head_d  = head_q + ptr_t'(pop);
    tail_d  = tail_q + ptr_t'(push);
    count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    valid_d = valid_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: the entry payload is not reset; the valid bits alone decide whether a slot means anything.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[tail_q] <= cpu_address;
      data_q[tail_q] <= cpu_write_data;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = '{valid: valid_q[i], addr: addr_q[i], data: data_q[i]};
    end
  end

  sb_forward_match u_forward_match (
    .addr_i    (cpu_address),
    .entries_i (entries),
    .head_i    (head_q),
    .tail_i    (tail_q),
    .hit_o     (fwd_hit),
    .data_o    (fwd_data)
  );

  // Memory port mux: loads first, then drains; everything quiet in reset.
  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    mem_memWrite   = 1'b0;
    mem_memRead    = 1'b0;
    cpu_read_data  = '0;
    if (!reset) begin
      if (load_req) begin
        mem_memRead   = 1'b1;
        mem_address   = cpu_address;
        cpu_read_data = fwd_hit ? fwd_data : mem_read_data;
      end else if (pop) begin
        mem_memWrite   = 1'b1;
        mem_address    = addr_q[head_q];
        mem_write_data = data_q[head_q];
      end
    end
  end

endmodule
